intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//   Peripheral-side interrupt controller. Latches event pulses from N_SRC sources
//   (uart rx/tx done, timer, ...) and raises irq to cpu. Reports the winning
//   source id on irq_cause. Completes a four-phase handshake against the cpu
//   ack bit, which the cpu writes via w_intr intr[0]. Sits in mother_board
//   between the peripherals and cpu; intr_en and the vector stay in the cpu sr.
// PARAMETERS
//   N_SRC    4   number of interrupt sources (1..16)
//   CAUSE_W  4   width of irq_cause; must satisfy 2**CAUSE_W >= N_SRC
// PORTS
//   clk          in   1        single clock
//   reset        in   1        synchronous, ACTIVE-LOW (0 = reset), sampled on clk rise
//   src_pulse    in   N_SRC    one-cycle event strobes from peripherals
//   mask_we      in   1        write enable for the mask register
//   mask_wdata   in   N_SRC    new mask value (1 = source enabled)
//   ovr_clr      in   1        clears all overrun bits
//   intr_en      in   1        cpu sr.intr_en; gates the irq output only
//   ack          in   1        cpu ack level (intr[0]); four-phase handshake
//   irq          out  1        interrupt request to cpu
//   irq_cause    out  CAUSE_W  source id of the request in service
//   pending      out  N_SRC    latched, not-yet-acked events (status)
//   overrun      out  N_SRC    event arrived while the same source was still pending
// BEHAVIOUR
//   - Reset (reset==0 at clk edge): state=IDLE; pending=0; overrun=0; mask=all-1;
//     irq=0; irq_cause=0. Reset wins over every other input. Mid-handshake reset
//     drops irq in the same edge, and ack is then ignored until state=IDLE.
//   - pending[i] sets on the edge that samples src_pulse[i]=1, regardless of mask.
//     If pending[i] is already 1, overrun[i] also sets (sticky until ovr_clr or reset).
//   - mask_we: mask updates on the edge. Masked sources keep latching but never win.
//   - FSM, all outputs registered:
//       IDLE : if |(pending & mask): latch irq_cause = lowest set index, go to REQ.
//       REQ  : irq = intr_en (combinational gate of the registered REQ flag).
//              irq_cause is held. On ack==1: clear pending[irq_cause], go to BUSY.
//       BUSY : irq=0; irq_cause is held. On ack==0, go to IDLE.
//   - Latency: pulse sampled at edge k, so pending=1 after k. At edge k+1 the FSM
//     goes to REQ, so irq=1 after k+1. Ack sampled at edge m gives irq=0 after m.
//   - Simultaneous src_pulse[c] and clear of pending[c] in REQ->BUSY: pending[c]
//     stays 1 (new event wins) and overrun[c] is NOT set.
//   - Back-to-back: BUSY->IDLE on edge n; the next REQ is no earlier than edge n+1.
//   - intr_en=0 while in REQ: irq is masked, but the state and cause are held.
//     ack is still honoured.
//   - Masking the in-service source while in REQ/BUSY does not abort service.
//   - ack==1 while in IDLE: no effect; IDLE cannot leave for REQ until ack==0.
//   - ovr_clr and a new overrun on the same edge: the bit ends at 1.
// STRUCTURE
//   - intr_package: typedef enum logic [1:0] {IDLE, REQ, BUSY} intr_state_t;
//     localparam ACK_IDX=0, INTR_EN_IDX=1, INTR_VEC_IDX=2 (w_intr register map).
//   - Sub-module intr_prio_enc: N_SRC request vector in -> valid + CAUSE_W
//     lowest-index id. Purely combinational; instantiated once.
//   - intr_ctrl holds the pending/overrun/mask registers and the FSM.
// TESTING
//   1 reset=0 for 2 cycles with src_pulse=4'hF -> irq=0, pending=0, overrun=0,
//     irq_cause=0.
//   2 intr_en=1, src_pulse=4'b0100 for 1 cycle -> pending=4'b0100 next cycle;
//     irq=1, irq_cause=2 one cycle later; ack=1 -> irq=0, pending=0;
//     ack=0 -> IDLE.
//   3 src_pulse=4'b1010 together -> cause=1 first; ack=1 then ack=0 ->
//     second REQ with cause=3; pending=0 after the second ack.
//   4 src_pulse[0] twice before ack -> overrun=4'b0001; ovr_clr=1 -> overrun=0.
//   5 mask_wdata=4'b1110, src_pulse[0] -> pending[0]=1, irq stays 0;
//     mask=4'hF -> irq=1, cause=0.
//   6 In REQ with cause=2: reset=0 -> irq=0, pending=0 next cycle.
//     Separately, intr_en=0 in REQ -> irq=0 with cause held; intr_en=1 -> irq=1.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared types and w_intr register map for the interrupt controller slice.
package intr_package;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } intr_state_t;

  localparam int ACK_IDX      = 0;
  localparam int INTR_EN_IDX  = 1;
  localparam int INTR_VEC_IDX = 2;

endpackage

// File: rtl/intr_ctrl_if.sv
// Peripheral/cpu-facing signal bundle of the interrupt controller.
interface intr_ctrl_if #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 4
);
  logic [N_SRC-1:0]   src_pulse;
  logic               mask_we;
  logic [N_SRC-1:0]   mask_wdata;
  logic               ovr_clr;
  logic               intr_en;
  logic               ack;
  logic               irq;
  logic [CAUSE_W-1:0] irq_cause;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   overrun;

  modport master (
    output src_pulse, mask_we, mask_wdata, ovr_clr, intr_en, ack,
    input  irq, irq_cause, pending, overrun
  );

  modport slave (
    input  src_pulse, mask_we, mask_wdata, ovr_clr, intr_en, ack,
    output irq, irq_cause, pending, overrun
  );
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled request vector.
module intr_prio_enc #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 4
) (
  input  logic [N_SRC-1:0]   req,
  output logic               valid,
  output logic [CAUSE_W-1:0] id
);
  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downwards so the lowest set index is written last.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = CAUSE_W'(i);
    end
  end
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/overrun/mask registers plus the
// IDLE/REQ/BUSY four-phase handshake against the cpu ack bit.
module intr_ctrl
  import intr_package::*;
#(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  intr_ctrl_if.slave bus
);
  intr_state_t        state_reg, state_next;
  logic [CAUSE_W-1:0] cause_reg, cause_next;
  logic [N_SRC-1:0]   pending_reg, pending_next;
  logic [N_SRC-1:0]   overrun_reg, overrun_next;
  logic [N_SRC-1:0]   mask_reg;
  logic [N_SRC-1:0]   clr_vec;
  logic               enc_valid;
  logic [CAUSE_W-1:0] enc_id;

  intr_prio_enc #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) u_prio_enc (
    .req   (pending_reg & mask_reg),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // A fresh pulse on the source being cleared wins and is not an overrun.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign clr_vec[gi] = (state_reg == REQ) && bus.ack && (cause_reg == CAUSE_W'(gi));
      assign pending_next[gi] = bus.src_pulse[gi] | (pending_reg[gi] & ~clr_vec[gi]);
      assign overrun_next[gi] = (bus.src_pulse[gi] & pending_reg[gi] & ~clr_vec[gi])
                              | (overrun_reg[gi] & ~bus.ovr_clr);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    unique case (state_reg)
      IDLE: begin
        // A stale ack (e.g. after a mid-handshake reset) blocks new requests.
        if (enc_valid && !bus.ack) begin
          state_next = REQ;
          cause_next = enc_id;
        end
      end
      REQ:  if (bus.ack)  state_next = BUSY;
      BUSY: if (!bus.ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cause_reg   <= '0;
      pending_reg <= '0;
      overrun_reg <= '0;
      mask_reg    <= '1;
    end else begin
      state_reg   <= state_next;
      cause_reg   <= cause_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      if (bus.mask_we) mask_reg <= bus.mask_wdata;
    end
  end

  assign bus.irq       = (state_reg == REQ) && bus.intr_en;
  assign bus.irq_cause = cause_reg;
  assign bus.pending   = pending_reg;
  assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with hand-computed expectations.
module tb_intr_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  intr_ctrl_if #(.N_SRC(4), .CAUSE_W(4)) bus ();

  intr_ctrl #(.N_SRC(4), .CAUSE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.src_pulse = 4'hF; bus.mask_we = 0; bus.mask_wdata = 0;
    bus.ovr_clr = 0; bus.intr_en = 0; bus.ack = 0;

    // 1: reset dominates incoming pulses
    tick(); tick();
    check("rst_irq", 32'(bus.irq), 0);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_cause", 32'(bus.irq_cause), 0);
    reset = 1'b1; bus.src_pulse = 0;
    tick();

    // 2: single source, full handshake
    bus.intr_en = 1; bus.src_pulse = 4'b0100;
    tick();
    check("t2_pending", 32'(bus.pending), 32'b0100);
    check("t2_irq_early", 32'(bus.irq), 0);
    bus.src_pulse = 0;
    tick();
    check("t2_irq", 32'(bus.irq), 1);
    check("t2_cause", 32'(bus.irq_cause), 2);
    bus.ack = 1; tick();
    check("t2_ack_irq", 32'(bus.irq), 0);
    check("t2_ack_pending", 32'(bus.pending), 0);
    bus.ack = 0; tick();
    check("t2_idle_irq", 32'(bus.irq), 0);

    // 3: two sources, lowest first, back-to-back
    bus.src_pulse = 4'b1010; tick();
    check("t3_pending", 32'(bus.pending), 32'b1010);
    bus.src_pulse = 0; tick();
    check("t3_cause1", 32'(bus.irq_cause), 1);
    check("t3_irq1", 32'(bus.irq), 1);
    bus.ack = 1; tick();
    check("t3_pending1", 32'(bus.pending), 32'b1000);
    bus.ack = 0; tick();
    check("t3_gap_irq", 32'(bus.irq), 0);
    tick();
    check("t3_irq2", 32'(bus.irq), 1);
    check("t3_cause3", 32'(bus.irq_cause), 3);
    bus.ack = 1; tick();
    check("t3_pending2", 32'(bus.pending), 0);
    bus.ack = 0; tick();

    // 4: overrun, clear, pulse-during-clear, clear-vs-set race
    bus.src_pulse = 4'b0001; tick();
    check("t4_pending", 32'(bus.pending), 32'b0001);
    tick();
    check("t4_overrun", 32'(bus.overrun), 32'b0001);
    check("t4_irq", 32'(bus.irq), 1);
    bus.src_pulse = 0; bus.ovr_clr = 1; tick();
    check("t4_ovr_clr", 32'(bus.overrun), 0);
    bus.ovr_clr = 0; bus.ack = 1; bus.src_pulse = 4'b0001; tick();
    check("t4_race_pending", 32'(bus.pending), 32'b0001);
    check("t4_race_overrun", 32'(bus.overrun), 0);
    bus.src_pulse = 0; bus.ack = 0; tick();
    tick();
    check("t4_rereq_irq", 32'(bus.irq), 1);
    check("t4_rereq_cause", 32'(bus.irq_cause), 0);
    bus.ack = 1; tick();
    bus.ack = 0; tick();
    check("t4_drain", 32'(bus.pending), 0);
    bus.src_pulse = 4'b0010; tick();
    bus.ovr_clr = 1; tick();
    check("t4_clr_set_race", 32'(bus.overrun), 32'b0010);
    bus.src_pulse = 0; tick();
    check("t4_clr_after", 32'(bus.overrun), 0);
    bus.ovr_clr = 0; bus.ack = 1; tick();
    bus.ack = 0; tick();

    // 5: masked source latches but does not win
    bus.mask_we = 1; bus.mask_wdata = 4'b1110; tick();
    bus.mask_we = 0; bus.src_pulse = 4'b0001; tick();
    check("t5_pending", 32'(bus.pending), 32'b0001);
    bus.src_pulse = 0; tick(); tick();
    check("t5_masked_irq", 32'(bus.irq), 0);
    bus.mask_we = 1; bus.mask_wdata = 4'hF; tick();
    bus.mask_we = 0; tick();
    check("t5_unmask_irq", 32'(bus.irq), 1);
    check("t5_unmask_cause", 32'(bus.irq_cause), 0);
    bus.ack = 1; tick();
    bus.ack = 0; tick();

    // ack held in IDLE blocks a new request
    bus.ack = 1; bus.src_pulse = 4'b0100; tick();
    bus.src_pulse = 0; tick();
    check("idle_ack_blocks", 32'(bus.irq), 0);
    bus.ack = 0; tick();
    check("idle_ack_release", 32'(bus.irq), 1);
    check("idle_ack_cause", 32'(bus.irq_cause), 2);

    // 6: intr_en gating and mid-handshake reset
    bus.intr_en = 0; #1;
    check("t6_gate_irq", 32'(bus.irq), 0);
    tick();
    check("t6_gate_cause", 32'(bus.irq_cause), 2);
    bus.intr_en = 1; #1;
    check("t6_ungate_irq", 32'(bus.irq), 1);
    reset = 0; tick();
    check("t6_rst_irq", 32'(bus.irq), 0);
    check("t6_rst_pending", 32'(bus.pending), 0);
    reset = 1; tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
